// File: rtl/lc3b_types_pkg.sv
// lc3b_types: shared LC-3b decode/execute types.
//   lc3b_word          16-bit datapath word
//   lc3b_control_word  control ROM output carried down the pipeline
//   id_ex_payload_t    everything the ID/EX boundary hands to execute
//   CTRL_BUBBLE        control word of an empty slot (all zero, so no side effects)
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       br_en;
  } lc3b_control_word;

  typedef struct packed {
    lc3b_control_word ctrl;
    lc3b_word         pc;
    lc3b_word         ir;
    lc3b_word         sr1;
    lc3b_word         sr2;
  } id_ex_payload_t;

  localparam lc3b_control_word CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_skid_stage_slot.sv
// id_ex_slot: one payload register plus its valid bit.
//   clk, reset     clock, async active-high reset (payload and valid to 0)
//   load_i         capture d_i and set valid
//   clear_i        drop valid (payload kept unless zero_ctrl_i)
//   zero_ctrl_i    force the held control word to CTRL_BUBBLE
//   d_i / q_o      payload in / held payload out
//   valid_o        slot holds an instruction
// load_i wins over clear_i/zero_ctrl_i; the transfer policy lives in the top.
module id_ex_slot
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           clear_i,
  input  logic           zero_ctrl_i,
  input  id_ex_payload_t d_i,
  output id_ex_payload_t q_o,
  output logic           valid_o
);

  id_ex_payload_t data_q, data_d;
  logic           valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = d_i;
      valid_d = 1'b1;
    end else begin
      if (clear_i)     valid_d = 1'b0;
      if (zero_ctrl_i) data_d.ctrl = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID/EX pipeline boundary with a 2-entry skid buffer.
// Main slot M drives execute; skid slot S catches the one instruction decode
// may send while execute is stalling, so in_ready is a plain register and
// out_ready never reaches decode combinationally.
//   clk, reset                    clock, async active-high reset
//   flush                         drop held and incoming instructions
//   in_valid/in_ready, in_*       decode side (ctrl, pc, ir, sr1, sr2)
//   out_valid/out_ready, out_*    execute side, driven from M
//   stall_cnt, bubble_cnt         saturating perf counters
// Build option: define ID_EX_PERF_EN to add stall_cnt/bubble_cnt.
module id_ex_skid_stage
  import lc3b_types::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  lc3b_control_word  in_ctrl,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_ir,
  input  logic [WORD_W-1:0] in_sr1,
  input  logic [WORD_W-1:0] in_sr2,
  output logic              out_valid,
  input  logic              out_ready,
  output lc3b_control_word  out_ctrl,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_ir,
  output logic [WORD_W-1:0] out_sr1,
  output logic [WORD_W-1:0] out_sr2
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  id_ex_payload_t in_pld, m_d, m_q, s_q;
  logic m_valid, s_valid;
  logic m_load, m_clear, m_zero;
  logic s_load, s_clear, s_zero;
  logic s_valid_d;
  logic in_ready_q, in_ready_d;
  logic accept, drain;

  always_comb begin
    in_pld.ctrl = in_ctrl;
    in_pld.pc   = in_pc;
    in_pld.ir   = in_ir;
    in_pld.sr1  = in_sr1;
    in_pld.sr2  = in_sr2;
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = m_valid & out_ready;

  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    m_zero    = 1'b0;
    m_d       = in_pld;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    s_zero    = 1'b0;
    s_valid_d = s_valid;
    if (flush) begin
      m_clear   = 1'b1;
      m_zero    = 1'b1;
      s_clear   = 1'b1;
      s_zero    = 1'b1;
      s_valid_d = 1'b0;
    end else if (drain && s_valid) begin
      // in_ready is low whenever S is full, so no accept can collide here
      m_load    = 1'b1;
      m_d       = s_q;
      s_clear   = 1'b1;
      s_zero    = 1'b1;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid || drain)) begin
      m_load = 1'b1;
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_d = 1'b1;
    end else if (drain) begin
      m_clear = 1'b1;
      m_zero  = 1'b1;
    end
  end

  // in_ready mirrors next-cycle S emptiness; held low through reset.
  assign in_ready_d = ~s_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready_q <= 1'b0;
    else       in_ready_q <= in_ready_d;
  end

  id_ex_slot u_slot_m (
    .clk         (clk),
    .reset       (reset),
    .load_i      (m_load),
    .clear_i     (m_clear),
    .zero_ctrl_i (m_zero),
    .d_i         (m_d),
    .q_o         (m_q),
    .valid_o     (m_valid)
  );

  id_ex_slot u_slot_s (
    .clk         (clk),
    .reset       (reset),
    .load_i      (s_load),
    .clear_i     (s_clear),
    .zero_ctrl_i (s_zero),
    .d_i         (in_pld),
    .q_o         (s_q),
    .valid_o     (s_valid)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_ctrl  = m_q.ctrl;
  assign out_pc    = m_q.pc;
  assign out_ir    = m_q.ir;
  assign out_sr1   = m_q.sr1;
  assign out_sr2   = m_q.sr2;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!m_valid && (bubble_cnt_q != '1))             bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  // CNT_W only sizes the perf counters; nothing to build without them.
  if (CNT_W == 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
module tb_id_ex_skid_stage;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  lc3b_control_word in_ctrl = '0;
  lc3b_control_word out_ctrl;
  logic [15:0]      in_pc = '0, in_ir = '0, in_sr1 = '0, in_sr2 = '0;
  logic [15:0]      out_pc, out_ir, out_sr1, out_sr2;
`ifdef ID_EX_PERF_EN
  logic [3:0]       stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_skid_stage #(.WORD_W(16), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_pc     (in_pc),
    .in_ir     (in_ir),
    .in_sr1    (in_sr1),
    .in_sr2    (in_sr2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .out_ir    (out_ir),
    .out_sr1   (out_sr1),
    .out_sr2   (out_sr2)
`ifdef ID_EX_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  function automatic lc3b_control_word mk_ctrl(input logic [15:0] pc);
    lc3b_control_word c;
    c = '0;
    c.opcode = lc3b_opcode'(pc[4:1]);
    c.load_regfile = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] mk_ir(input logic [15:0] pc);
    return (pc * 16'd3) ^ 16'hA5A5;
  endfunction

  task automatic set_in(input logic v, input logic [15:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ir    = mk_ir(pc);
    in_sr1   = ~pc;
    in_sr2   = pc + 16'h0100;
    in_ctrl  = mk_ctrl(pc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_in(1'b0, 16'h0);
    out_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== CTRL_BUBBLE) begin errors++; $display("FAIL reset_out_ctrl: got %h exp 0", out_ctrl); end
    reset = 1'b0;
    step;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_stream;
    logic [15:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 16'(2 * i);
      set_in(1'b1, pc);
      step;
      checks++; if (out_valid !== 1'b1 || out_pc !== pc) begin errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, pc); end
      checks++; if (out_ir !== mk_ir(pc) || out_ctrl !== mk_ctrl(pc)) begin errors++; $display("FAIL stream_payload[%0d]: got ir=%h ctrl=%h exp ir=%h ctrl=%h", i, out_ir, out_ctrl, mk_ir(pc), mk_ctrl(pc)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", i, in_ready); end
    end
    set_in(1'b0, 16'h0);
    step;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_BUBBLE) begin errors++; $display("FAIL stream_drained: got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, out_ctrl); end
  endtask

  task automatic test_skid;
    out_ready = 1'b0;
    set_in(1'b1, 16'h0010);
    step;
    checks++; if (out_pc !== 16'h0010 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_first: got pc=%h rdy=%b exp pc=0010 rdy=1", out_pc, in_ready); end
    set_in(1'b1, 16'h0012);
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0010 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_full: got v=%b pc=%h rdy=%b exp v=1 pc=0010 rdy=0", out_valid, out_pc, in_ready); end
    set_in(1'b1, 16'h0014);
    step;
    checks++; if (out_pc !== 16'h0010 || out_sr2 !== 16'h0110 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_hold: got pc=%h sr2=%h rdy=%b exp pc=0010 sr2=0110 rdy=0", out_pc, out_sr2, in_ready); end
    set_in(1'b0, 16'h0);
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0012 || out_sr1 !== ~16'h0012) begin errors++; $display("FAIL skid_second: got v=%b pc=%h sr1=%h exp v=1 pc=0012 sr1=ffed", out_valid, out_pc, out_sr1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b exp 1", in_ready); end
    step;
    checks++; if (out_valid !== 1'b0 || out_pc === 16'h0014) begin errors++; $display("FAIL skid_end: got v=%b pc=%h exp v=0 (0014 dropped)", out_valid, out_pc); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_in(1'b1, 16'h0030);
    step;
    set_in(1'b1, 16'h0032);
    step;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill: got rdy=%b exp 0", in_ready); end
    flush = 1'b1;
    set_in(1'b1, 16'h0020);
    step;
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_BUBBLE || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got v=%b ctrl=%h rdy=%b exp v=0 ctrl=0 rdy=1", out_valid, out_ctrl, in_ready); end
    set_in(1'b0, 16'h0);
    out_ready = 1'b1;
    repeat (2) begin
      step;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got v=%b pc=%h exp v=0", out_valid, out_pc); end
    end
    // flush with in_ready high must also drop the incoming instruction
    out_ready = 1'b0;
    set_in(1'b1, 16'h0040);
    step;
    flush = 1'b1;
    set_in(1'b1, 16'h0042);
    step;
    flush = 1'b0;
    set_in(1'b0, 16'h0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_BUBBLE) begin errors++; $display("FAIL flush_accept_dropped: got v=%b pc=%h exp v=0", out_valid, out_pc); end
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_settle: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    logic [15:0] seq, exp_pc, held_pc, held_ir;
    lc3b_control_word held_ctrl;
    logic held, acc, drn;
    seq = 16'h1000;
    held = 1'b0;
    held_pc = '0;
    held_ir = '0;
    held_ctrl = '0;
    flush = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (held) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== held_pc || out_ir !== held_ir || out_ctrl !== held_ctrl) begin errors++; $display("FAIL rnd_stable@%0d: got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, held_pc); end
      end
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", i, in_ready, q.size() < 2); end
      set_in(1'($urandom_range(0, 1)), seq);
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra@%0d: got pc=%h exp none", i, out_pc);
        end else begin
          exp_pc = q.pop_front();
          if (out_pc !== exp_pc || out_ir !== mk_ir(exp_pc) || out_sr1 !== ~exp_pc ||
              out_sr2 !== exp_pc + 16'h0100 || out_ctrl !== mk_ctrl(exp_pc)) begin
            errors++; $display("FAIL rnd_order@%0d: got pc=%h ir=%h exp pc=%h ir=%h", i, out_pc, out_ir, exp_pc, mk_ir(exp_pc));
          end
        end
      end
      if (acc) begin
        q.push_back(seq);
        seq = seq + 16'h1;
      end
      held = out_valid && !out_ready;
      held_pc = out_pc;
      held_ir = out_ir;
      held_ctrl = out_ctrl;
      step;
    end
    set_in(1'b0, 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      exp_pc = q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin errors++; $display("FAIL rnd_tail: got v=%b pc=%h exp v=1 pc=%h", out_valid, out_pc, exp_pc); end
      step;
    end
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final: got left=%0d v=%b exp left=0 v=0", q.size(), out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    set_in(1'b1, 16'h0050);
    in_ctrl.opcode = op_add;
    step;
    set_in(1'b0, 16'h0);
    checks++; if (out_valid !== 1'b1 || out_ctrl.opcode !== op_add) begin errors++; $display("FAIL arst_loaded: got v=%b op=%h exp v=1 op=1", out_valid, out_ctrl.opcode); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_BUBBLE) begin errors++; $display("FAIL arst_immediate: got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, out_ctrl); end
    #1 reset = 1'b0;
    step;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_recover: got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf;
    reset = 1'b1;
    set_in(1'b0, 16'h0);
    out_ready = 1'b0;
    step;
    checks++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin errors++; $display("FAIL perf_reset: got st=%h bu=%h exp 0 0", stall_cnt, bubble_cnt); end
    reset = 1'b0;
    repeat (5) step;
    checks++; if (bubble_cnt !== 4'h5 || stall_cnt !== 4'h0) begin errors++; $display("FAIL perf_bubble: got st=%h bu=%h exp 0 5", stall_cnt, bubble_cnt); end
    set_in(1'b1, 16'h0060);
    step;
    set_in(1'b0, 16'h0);
    repeat (20) step;
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL perf_stall_sat: got %h exp f", stall_cnt); end
    checks++; if (bubble_cnt !== 4'h6) begin errors++; $display("FAIL perf_bubble_hold: got %h exp 6", bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_skid;
    test_flush;
    test_random;
    test_async_reset;
`ifdef ID_EX_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout exp completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Pipeline boundary between decode, where the control ROM produces the control word, and execute.
- Captures one decoded instruction per cycle: control word, PC, IR, operands.
- Presents the captured instruction to execute with a valid/ready handshake.
- A 2-entry skid buffer makes in_ready purely registered, so back-pressure from execute never forms a combinational path into decode.
- Supports flush (branch/trap redirect); flushed slots become bubbles with an all-zero control word.

Parameters:
- WORD_W, 16, width of PC, IR and operand fields (lc3b_word).
- CNT_W, 16, width of the performance counters (used only with ID_EX_PERF_EN).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  lc3b_control_word  control word from the control ROM.
- in_pc  in  WORD_W  PC of the instruction.
- in_ir  in  WORD_W  instruction register.
- in_sr1  in  WORD_W  source operand 1.
- in_sr2  in  WORD_W  source operand 2.
- out_valid  out  1  execute payload valid.
- out_ready  in  1  execute accepts the payload.
- out_ctrl, out_pc, out_ir, out_sr1, out_sr2  out  as inputs  registered payload.
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready (ID_EX_PERF_EN only).
- bubble_cnt  out  CNT_W  cycles with ~out_valid (ID_EX_PERF_EN only).

Behaviour:
- Storage: main register M, which drives the out_* ports, and skid register S. Each has a valid bit.
- Reset: asynchronous, active-high. All valid bits, payloads and counters go to 0, so out_valid=0 and out_ctrl=0. in_ready=1 from the first edge after reset deassertion.
- in_ready = ~S.valid, as a register output. No combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Per cycle, in priority order:
  - flush=1: M.valid and S.valid cleared; M/S control words zeroed. An incoming accept is dropped. in_ready=1 next cycle.
  - Drain & S.valid: S moves to M; S.valid cleared. Any accept in the same cycle is impossible, because in_ready=0.
  - Accept & (~M.valid | Drain): payload loads into M; M.valid=1.
  - Accept & M.valid & ~Drain: payload loads into S; S.valid=1, so in_ready drops next cycle.
  - Drain with nothing incoming: M.valid cleared; M.ctrl zeroed so a bubble shows a zero control word.
- Latency: 1 cycle from accept to out_valid when M is empty.
- Throughput: 1 instruction per cycle while out_ready=1.
- Order is strictly FIFO (M before S). No instruction is duplicated or lost except by flush.
- Payload in M is held stable while out_valid & ~out_ready.
- Full (S.valid): in_ready=0. Any in_valid is ignored without side effects.
- Empty: out_valid=0, out_ctrl=0.
- Reset asserted mid-transfer: held instructions are discarded immediately, without waiting for the clock.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - stall_cnt and bubble_cnt exist and increment per their definitions.
  - Both saturate at all-ones rather than wrap.
  - Both clear on reset; flush does not clear them.
- Undefined: both ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- lc3b_types package:
  - lc3b_word and lc3b_control_word, the existing types.
  - New struct id_ex_payload_t {ctrl, pc, ir, sr1, sr2}.
  - Constant CTRL_BUBBLE = '0.
- Sub-module id_ex_slot: one payload register plus valid bit, with load, clear and zero-ctrl controls. Instantiated twice (M and S); the top holds the transfer logic.

Test Plan:
- Reset, then stream in_valid=1 with out_ready=1, pc=0x0000,0x0002,0x0004 → out_pc appears one cycle later in order; out_valid continuous; in_ready stays 1.
- out_ready=0 while sending pc=0x0010 then 0x0012 → M=0x0010, S=0x0012, in_ready=0. Raising out_ready gives 0x0010 then 0x0012 on consecutive cycles; in_ready=1 the cycle after S empties.
- With both slots full, assert flush with in_valid=1, pc=0x0020 → next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x0020 never appears.
- Assert reset asynchronously mid-cycle while M holds an instruction with opcode op_add → out_valid and out_ctrl go to 0 before the next clock edge.
- Drive random in_valid/out_ready for 10k cycles against a scoreboard → no loss, duplication or reorder; payload stable whenever out_valid & ~out_ready.
- ID_EX_PERF_EN with CNT_W=4 and 20 cycles of out_valid & ~out_ready → stall_cnt saturates at 0xF; bubble_cnt counts the empty cycles after reset.
